// File: rtl/parking_pkg.sv
// Shared definitions for the car-park gate controllers.
// Both the exit and entrance sides import this package.
//   exit_state_t : exit-gate FSM states
//   code_t       : 2-bit driver payment/exit code
//   EXIT_CODE_DEF, CAPACITY_DEF : default parameter values
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_CODE  = 3'd1,
    S_WRONG_CODE = 3'd2,
    S_OPEN       = 3'd3,
    S_STOP       = 3'd4
  } exit_state_t;

  typedef logic [1:0] code_t;

  localparam code_t EXIT_CODE_DEF = 2'b11;
  localparam int    CAPACITY_DEF  = 8;

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down occupancy counter for the car park.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_inc, i_dec : count one car in / one car out
//   o_occ        : current occupancy
//   o_full       : occupancy == CAPACITY
//   o_empty      : occupancy == 0
//   o_err        : sticky, set when an increment at full or a decrement at
//                  empty is attempted; cleared only by reset
module parking_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int OCC_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [OCC_W-1:0] o_occ,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  logic [OCC_W-1:0] r_occ;
  logic             r_err;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_occ == OCC_W'(CAPACITY));
  assign w_empty = (r_occ == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      // inc and dec together cancel out; no bound can be crossed
      if (i_inc && !i_dec) begin
        if (w_full) r_err <= 1'b1;
        else        r_occ <= r_occ + OCC_W'(1);
      end else if (i_dec && !i_inc) begin
        if (w_empty) r_err <= 1'b1;
        else         r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  assign o_occ   = r_occ;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_err   = r_err;

endmodule

// File: rtl/parking_exit_gate.sv
// Exit-side car-park gate controller.
// Waits a settle time after a car arrives on the exit loop, checks the exit
// code, drives barrier and lamps, and tracks lot occupancy.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sensor_exit   : car present on the exit loop
//   sensor_clear  : car has passed the barrier
//   exit_code     : driver's code
//   car_entered   : 1-cycle pulse from the entrance controller
//   GREEN_LED, RED_LED, gate_open : registered Moore lamp/barrier outputs
//   car_exited    : 1-cycle pulse after an exit completes
//   occupancy, full, empty, count_err : occupancy status
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int    WAIT_CYCLES = 4,
  parameter code_t EXIT_CODE   = EXIT_CODE_DEF,
  parameter int    CAPACITY    = CAPACITY_DEF,
  parameter int    OCC_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_exit,
  input  logic             sensor_clear,
  input  code_t            exit_code,
  input  logic             car_entered,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic             gate_open,
  output logic             car_exited,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             count_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  exit_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_green, r_red, r_gate, r_exited;
  logic             w_green_nxt, w_red_nxt, w_gate_nxt;
  logic             w_dec;
  logic             w_code_ok;

  assign w_code_ok = (exit_code == EXIT_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_green  <= 1'b0;
      r_red    <= 1'b0;
      r_gate   <= 1'b0;
      r_exited <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_green  <= w_green_nxt;
      r_red    <= w_red_nxt;
      r_gate   <= w_gate_nxt;
      r_exited <= w_dec;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dec       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sensor_exit) begin
          w_state_nxt = S_WAIT_CODE;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_CODE: begin
        if (!sensor_exit)           w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = w_code_ok ? S_OPEN : S_WRONG_CODE;
        else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_WRONG_CODE, S_STOP: begin
        // a departing car beats a late correct code
        if (!sensor_exit)   w_state_nxt = S_IDLE;
        else if (w_code_ok) w_state_nxt = S_OPEN;
      end
      S_OPEN: begin
        if (sensor_clear) begin
          w_dec       = 1'b1;
          w_state_nxt = sensor_exit ? S_STOP : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land with the state.
    w_green_nxt = (w_state_nxt == S_OPEN);
    w_gate_nxt  = (w_state_nxt == S_OPEN);
    case (w_state_nxt)
      S_WAIT_CODE:         w_red_nxt = 1'b1;
      // blink: 1 on entry, toggle while staying
      S_WRONG_CODE, S_STOP: w_red_nxt = (r_state == w_state_nxt) ? ~r_red : 1'b1;
      default:             w_red_nxt = 1'b0;
    endcase
  end

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .OCC_W    (OCC_W)
  ) u_occ (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (car_entered),
    .i_dec   (w_dec),
    .o_occ   (occupancy),
    .o_full  (full),
    .o_empty (empty),
    .o_err   (count_err)
  );

  assign GREEN_LED  = r_green;
  assign RED_LED    = r_red;
  assign gate_open  = r_gate;
  assign car_exited = r_exited;

endmodule

// File: doc/parking_exit_gate.md
Name: parking_exit_gate

Overview:
Exit-side controller for the car park. It is the counterpart of the entrance gate controller.
- Detects a car on the exit loop and waits a fixed settle time, then checks a 2-bit exit (payment) code.
- Drives the exit barrier and the red/green lamps.
- Keeps the lot occupancy count, using car_entered pulses from the entrance side and its own exit events.

Parameters:
- WAIT_CYCLES, 4: cycles spent in WAIT_CODE before exit_code is evaluated (must be >= 1).
- EXIT_CODE, 2'b11: the accepted exit code value.
- CAPACITY, 8: number of bays; occupancy saturates here.
- OCC_W, 4: occupancy width; must satisfy 2**OCC_W > CAPACITY.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sensor_exit  in  1  car present on the exit loop.
- sensor_clear  in  1  car has passed beyond the barrier.
- exit_code  in  2  code presented by the driver.
- car_entered  in  1  single-cycle pulse from the entrance controller when a car is admitted.
- GREEN_LED  out  1  barrier open / proceed.
- RED_LED  out  1  steady = wait; blinking = wrong code or stop.
- gate_open  out  1  barrier actuator.
- car_exited  out  1  single-cycle pulse when an exit completes.
- occupancy  out  OCC_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- count_err  out  1  sticky flag: increment at full or decrement at empty was attempted.

Behaviour:
- Reset (synchronous, active-high; wins over every other input):
  - state = IDLE, wait counter = 0, occupancy = 0.
  - GREEN_LED = 0, RED_LED = 0, gate_open = 0, car_exited = 0, count_err = 0, empty = 1, full = 0.
  - Reset asserted mid-operation aborts any state on that edge; the barrier closes the next cycle.
- Outputs are Moore:
  - LEDs and gate_open are registered and decoded from the state; they change on the same edge that enters the new state.
- States and transitions (evaluated at each rising edge):
  - IDLE: all lamps off.
    - sensor_exit = 1 -> WAIT_CODE, counter cleared to 0.
  - WAIT_CODE: RED_LED = 1 steady, GREEN_LED = 0.
    - sensor_exit = 0 -> IDLE (car reversed).
    - Otherwise the counter increments each cycle.
    - When the counter == WAIT_CYCLES-1: exit_code == EXIT_CODE -> OPEN, else -> WRONG_CODE.
  - WRONG_CODE: GREEN_LED = 0; RED_LED blinks, set to 1 on entry and toggled every cycle after.
    - sensor_exit = 0 -> IDLE.
    - exit_code == EXIT_CODE -> OPEN.
    - sensor_exit = 0 has priority over a correct code.
  - OPEN: GREEN_LED = 1, RED_LED = 0, gate_open = 1.
    - On sensor_clear = 1: car_exited pulses on the next cycle and occupancy decrements.
    - Then, if sensor_exit = 1 on that same edge (tailgater) -> STOP, else -> IDLE.
  - STOP: barrier closed; GREEN_LED = 0; RED_LED blinks as in WRONG_CODE.
    - sensor_exit = 0 -> IDLE.
    - exit_code == EXIT_CODE -> OPEN.
- Occupancy:
  - inc = car_entered; dec = exit event (OPEN and sensor_clear).
  - inc and dec together -> unchanged, no error.
  - inc at CAPACITY -> hold, count_err = 1.
  - dec at 0 -> hold, count_err = 1, but the exit still completes (barrier and car_exited behave normally).
  - full and empty are combinational from the occupancy register.
- Encodings: undefined state encodings recover to IDLE.

Decomposition:
- Shared package parking_pkg, holding:
  - the exit-gate state enum (IDLE, WAIT_CODE, WRONG_CODE, OPEN, STOP);
  - the code type (2-bit);
  - the default EXIT_CODE constant;
  - the default CAPACITY constant.
- The entrance controller reuses the package.
- One natural sub-module, parking_occupancy_counter: a saturating up/down counter with full, empty and the sticky error flag. It is instantiated here and is reusable by a lot-level monitor.

Test Plan:
1. Reset: hold reset = 1 for 2 cycles with sensor_exit = 1 -> all outputs 0, empty = 1, occupancy = 0; after release, WAIT_CODE is entered on the first edge.
2. Good exit: 3 car_entered pulses -> occupancy = 3. Then sensor_exit = 1 with exit_code = 2'b11 -> RED_LED steady for 4 cycles, then GREEN_LED = 1 and gate_open = 1. Then sensor_clear = 1 -> car_exited pulses once, occupancy = 2, state returns to IDLE.
3. Wrong code: exit_code = 2'b10 at the decision cycle -> RED_LED alternates 1,0,1,...; change to 2'b11 -> GREEN_LED = 1 the next cycle. Separately, drop sensor_exit while in WRONG_CODE -> IDLE, lamps off.
4. Tailgate: in OPEN, assert sensor_clear = 1 and sensor_exit = 1 together -> STOP, gate_open = 0, RED_LED blinks, occupancy decremented once. Then exit_code = 2'b11 -> OPEN again.
5. Saturation: 8 car_entered pulses -> full = 1; a 9th pulse -> occupancy stays 8 and count_err = 1. car_entered together with an exit at occupancy 5 -> stays 5.
6. Underflow and mid-operation reset: complete an exit at occupancy 0 -> occupancy stays 0, count_err = 1, car_exited still pulses. Assert reset while in OPEN -> gate_open = 0 and count_err = 0 after that edge.
